// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver.
// Patterns are active-low, bit order g..a.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment pattern.
// Purely combinational lookup.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed N-digit 7-segment driver with dwell,
// blanking, leading-zero suppression and framed loads.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS       = 3,
    parameter int DWELL        = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                  CLK,
    input  logic                  BTNR,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic [DIGITS-1:0]     DIG_EN,
    input  logic                  LOAD,
    output logic                  PENDING,
    output logic                  FRAME,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [DIGITS-1:0]     AN
);

    localparam int CW = $clog2(DWELL);
    localparam int IW = idx_width(DIGITS);

    if (DIGITS < 1) begin : g_chk_digits
        $error("seg_scan_mux: DIGITS must be >= 1");
    end
    if (DWELL < 2) begin : g_chk_dwell
        $error("seg_scan_mux: DWELL must be >= 2");
    end
    if (BLANK_CYCLES >= DWELL) begin : g_chk_blank
        $error("seg_scan_mux: BLANK_CYCLES must be < DWELL");
    end

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   sh_data;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_en;
    logic [4*DIGITS-1:0]   act_data;
    logic [DIGITS-1:0]     act_dp;
    logic [DIGITS-1:0]     act_en;

    logic                  slot_end;
    logic                  last_dig;
    logic                  boundary;

    assign slot_end = (cnt == CW'(DWELL - 1));
    assign last_dig = (idx == IW'(DIGITS - 1));
    assign boundary = slot_end && last_dig;

    always_ff @(posedge CLK or posedge BTNR) begin
        if (BTNR) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= last_dig ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Commit uses the shadow as it was before any same-cycle LOAD,
    // so a LOAD on the boundary stays pending for the next frame.
    always_ff @(posedge CLK or posedge BTNR) begin
        if (BTNR) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_en    <= '0;
            act_data <= '0;
            act_dp   <= '0;
            act_en   <= '0;
            PENDING  <= 1'b0;
        end else begin
            if (LOAD) begin
                sh_data <= DATA;
                sh_dp   <= DP_IN;
                sh_en   <= DIG_EN;
            end
            if (boundary && PENDING) begin
                act_data <= sh_data;
                act_dp   <= sh_dp;
                act_en   <= sh_en;
            end
            if (LOAD) begin
                PENDING <= 1'b1;
            end else if (boundary) begin
                PENDING <= 1'b0;
            end
        end
    end

    logic [DIGITS-1:0] zero_up;
    logic [DIGITS-1:0] supp;
    logic              run_zero;

    always_comb begin
        zero_up  = '0;
        run_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero   = run_zero && (act_data[4*i +: 4] == 4'h0);
            zero_up[i] = run_zero;
        end
    end

    assign supp = (LZ_SUPPRESS != 0) ?
                  (zero_up & ~DIGITS'(1)) : '0;

    logic [3:0] nib;
    logic       en_sel;
    logic       dp_sel;
    logic       sup_sel;
    logic       visible;
    logic [6:0] seg_pat;

    always_comb begin
        nib     = '0;
        en_sel  = 1'b0;
        dp_sel  = 1'b0;
        sup_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib     = act_data[4*i +: 4];
                en_sel  = act_en[i];
                dp_sel  = act_dp[i];
                sup_sel = supp[i];
            end
        end
    end

    assign visible = en_sel && !sup_sel &&
                     (cnt >= CW'(BLANK_CYCLES));

    hex7seg u_hex (
        .nibble (nib),
        .seg    (seg_pat)
    );

    always_ff @(posedge CLK or posedge BTNR) begin
        if (BTNR) begin
            AN    <= '1;
            SEG   <= SEG_OFF;
            DP    <= 1'b1;
            FRAME <= 1'b0;
        end else begin
            FRAME <= boundary;
            if (visible) begin
                AN  <= ~(DIGITS'(1) << idx);
                SEG <= seg_pat;
                DP  <= ~dp_sel;
            end else begin
                AN  <= '1;
                SEG <= SEG_OFF;
                DP  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (3 digits, dwell 8, blank 2).
// Two instances share stimulus: LZ off (u_dut) and LZ on (u_lz).
module tb_seg_scan_mux;

    logic        CLK;
    logic        BTNR;
    logic [11:0] DATA;
    logic [2:0]  DP_IN;
    logic [2:0]  DIG_EN;
    logic        LOAD;

    logic        pend0, frame0, dp0;
    logic [6:0]  seg0;
    logic [2:0]  an0;
    logic        pend1, frame1, dp1;
    logic [6:0]  seg1;
    logic [2:0]  an1;

    int total;
    int bad;

    logic [2:0] an_tab [3] = '{3'b110, 3'b101, 3'b011};

    seg_scan_mux #(
        .DIGITS(3), .DWELL(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(0)
    ) u_dut (
        .CLK(CLK), .BTNR(BTNR), .DATA(DATA), .DP_IN(DP_IN),
        .DIG_EN(DIG_EN), .LOAD(LOAD), .PENDING(pend0),
        .FRAME(frame0), .SEG(seg0), .DP(dp0), .AN(an0)
    );

    seg_scan_mux #(
        .DIGITS(3), .DWELL(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(1)
    ) u_lz (
        .CLK(CLK), .BTNR(BTNR), .DATA(DATA), .DP_IN(DP_IN),
        .DIG_EN(DIG_EN), .LOAD(LOAD), .PENDING(pend1),
        .FRAME(frame1), .SEG(seg1), .DP(dp1), .AN(an1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        BTNR = 1'b1;
        step();
        step();
        total++;
        if (an0 !== 3'b111 || seg0 !== 7'h7F || dp0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_out an=%b seg=%h dp=%b want 111/7f/1",
                     an0, seg0, dp0);
        end
        total++;
        if (pend0 !== 1'b0 || frame0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags pend=%b frame=%b want 0/0",
                     pend0, frame0);
        end
        BTNR = 1'b0;
        for (int j = 1; j <= 48; j++) begin
            step();
            total++;
            if (an0 !== 3'b111 || an1 !== 3'b111 || seg0 !== 7'h7F) begin
                bad++;
                $display("FAIL dark_frame j=%0d an=%b/%b seg=%h want dark",
                         j, an0, an1, seg0);
            end
            total++;
            if (frame0 !== (j == 24 || j == 48)) begin
                bad++;
                $display("FAIL frame_pulse j=%0d got=%b want=%b",
                         j, frame0, (j == 24 || j == 48));
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [6:0] seg_tab [3];
        int lows [3];
        int s, c;
        logic [2:0] ea;
        logic [6:0] es;
        logic       ed;
        seg_tab = '{7'h78, 7'h46, 7'h79};
        lows    = '{0, 0, 0};
        DATA = 12'h1C7;
        DIG_EN = 3'b111;
        DP_IN = 3'b010;
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        total++;
        if (pend0 !== 1'b1) begin
            bad++;
            $display("FAIL basic_pend_rise got=%b want=1", pend0);
        end
        for (int k = 2; k <= 24; k++) step();
        total++;
        if (frame0 !== 1'b1 || pend0 !== 1'b0) begin
            bad++;
            $display("FAIL basic_commit frame=%b pend=%b want 1/0",
                     frame0, pend0);
        end
        for (int k = 1; k <= 24; k++) begin
            step();
            s = (k - 1) / 8;
            c = (k - 1) % 8;
            ea = (c >= 2) ? an_tab[s] : 3'b111;
            es = (c >= 2) ? seg_tab[s] : 7'h7F;
            ed = (c >= 2 && s == 1) ? 1'b0 : 1'b1;
            if (an0[s] === 1'b0) lows[s]++;
            total++;
            if (an0 !== ea || seg0 !== es || dp0 !== ed) begin
                bad++;
                $display("FAIL basic k=%0d an=%b seg=%h dp=%b want %b/%h/%b",
                         k, an0, seg0, dp0, ea, es, ed);
            end
        end
        for (int d = 0; d < 3; d++) begin
            total++;
            if (lows[d] != 6) begin
                bad++;
                $display("FAIL basic_low_count d=%0d got=%0d want=6",
                         d, lows[d]);
            end
        end
    endtask

    task automatic test_double_load();
        int s, c;
        DP_IN = 3'b000;
        DIG_EN = 3'b111;
        DATA = 12'h111;
        LOAD = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            step();
            LOAD = 1'b0;
            if (k == 4) begin
                DATA = 12'h222;
                LOAD = 1'b1;
            end
            total++;
            if (pend0 !== 1'b1) begin
                bad++;
                $display("FAIL dbl_pend k=%0d got=%b want=1", k, pend0);
            end
        end
        step();
        total++;
        if (frame0 !== 1'b1 || pend0 !== 1'b0) begin
            bad++;
            $display("FAIL dbl_commit frame=%b pend=%b want 1/0",
                     frame0, pend0);
        end
        for (int k = 1; k <= 24; k++) begin
            step();
            s = (k - 1) / 8;
            c = (k - 1) % 8;
            if (c == 4) begin
                total++;
                if (an0 !== an_tab[s] || seg0 !== 7'h24) begin
                    bad++;
                    $display("FAIL dbl_show s=%0d an=%b seg=%h want %b/24",
                             s, an0, seg0, an_tab[s]);
                end
            end
        end
    endtask

    task automatic test_load_on_boundary();
        int s, c;
        DATA = 12'h333;
        LOAD = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            step();
            LOAD = 1'b0;
            if (k == 23) begin
                DATA = 12'h444;
                LOAD = 1'b1;
            end
        end
        step();
        LOAD = 1'b0;
        total++;
        if (frame0 !== 1'b1 || pend0 !== 1'b1) begin
            bad++;
            $display("FAIL bnd_pend frame=%b pend=%b want 1/1",
                     frame0, pend0);
        end
        for (int k = 1; k <= 24; k++) begin
            step();
            s = (k - 1) / 8;
            c = (k - 1) % 8;
            if (c == 4) begin
                total++;
                if (an0 !== an_tab[s] || seg0 !== 7'h30) begin
                    bad++;
                    $display("FAIL bnd_old s=%0d an=%b seg=%h want %b/30",
                             s, an0, seg0, an_tab[s]);
                end
            end
        end
        total++;
        if (frame0 !== 1'b1 || pend0 !== 1'b0) begin
            bad++;
            $display("FAIL bnd_commit2 frame=%b pend=%b want 1/0",
                     frame0, pend0);
        end
        for (int k = 1; k <= 24; k++) begin
            step();
            s = (k - 1) / 8;
            c = (k - 1) % 8;
            if (c == 4) begin
                total++;
                if (an0 !== an_tab[s] || seg0 !== 7'h19) begin
                    bad++;
                    $display("FAIL bnd_new s=%0d an=%b seg=%h want %b/19",
                             s, an0, seg0, an_tab[s]);
                end
            end
        end
    endtask

    task automatic test_lz(input logic [11:0] val,
                           input logic [6:0]  e0,
                           input logic [6:0]  e1,
                           input logic [6:0]  e2);
        logic [6:0] et [3];
        logic [2:0] ea;
        int s, c;
        et = '{e0, e1, e2};
        DATA = val;
        DIG_EN = 3'b111;
        DP_IN = 3'b000;
        LOAD = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            LOAD = 1'b0;
        end
        total++;
        if (frame1 !== 1'b1) begin
            bad++;
            $display("FAIL lz_sync val=%h frame=%b want 1", val, frame1);
        end
        for (int k = 1; k <= 24; k++) begin
            step();
            s = (k - 1) / 8;
            c = (k - 1) % 8;
            if (c == 4) begin
                ea = (et[s] == 7'h7F) ? 3'b111 : an_tab[s];
                total++;
                if (an1 !== ea || seg1 !== et[s] || dp1 !== 1'b1) begin
                    bad++;
                    $display("FAIL lz val=%h s=%0d an=%b seg=%h want %b/%h",
                             val, s, an1, seg1, ea, et[s]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        DATA = 12'h666;
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        total++;
        if (pend0 !== 1'b1) begin
            bad++;
            $display("FAIL mid_pend got=%b want=1", pend0);
        end
        for (int k = 2; k <= 12; k++) step();
        total++;
        if (an0 !== 3'b101 || seg0 !== 7'h12) begin
            bad++;
            $display("FAIL mid_pre an=%b seg=%h want 101/12", an0, seg0);
        end
        #2 BTNR = 1'b1;
        #1;
        total++;
        if (an0 !== 3'b111 || seg0 !== 7'h7F || dp0 !== 1'b1 ||
            pend0 !== 1'b0 || frame0 !== 1'b0) begin
            bad++;
            $display("FAIL mid_async an=%b seg=%h dp=%b pend=%b frame=%b",
                     an0, seg0, dp0, pend0, frame0);
        end
        step();
        step();
        BTNR = 1'b0;
        for (int j = 1; j <= 48; j++) begin
            step();
            total++;
            if (an0 !== 3'b111 || an1 !== 3'b111 || pend0 !== 1'b0) begin
                bad++;
                $display("FAIL mid_dark j=%0d an=%b/%b pend=%b want dark",
                         j, an0, an1, pend0);
            end
            total++;
            if (frame0 !== (j == 24 || j == 48)) begin
                bad++;
                $display("FAIL mid_frame j=%0d got=%b", j, frame0);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        BTNR   = 1'b1;
        LOAD   = 1'b0;
        DATA   = '0;
        DP_IN  = '0;
        DIG_EN = '0;
        test_reset();
        test_basic_scan();
        test_double_load();
        test_load_on_boundary();
        test_lz(12'h005, 7'h12, 7'h7F, 7'h7F);
        test_lz(12'h000, 7'h40, 7'h7F, 7'h7F);
        test_lz(12'h050, 7'h40, 7'h12, 7'h7F);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
